// File: rtl/data_bus_responder.sv
// Responder side of the core data bus: local RAM with byte/half/word stores,
// GPIO output register and compare timer. Reads are combinational.
module data_bus_responder #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_wr_en,
  input  logic [31:0]       dAddr,
  input  logic [31:0]       dWdata,
  input  logic [1:0]        d_size,
  input  logic [2:0]        load_type,
  output logic [31:0]       dRdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       mem_q [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              autoclr_q, autoclr_d;
  logic              match_q, match_d;

  logic          ram_hit, mmio_hit, ram_we, mmio_we, hit;
  logic [AW-1:0] word_idx;
  logic [2:0]    reg_sel;
  logic [3:0]    be;
  logic [31:0]   wdata_al;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign ram_hit  = (dAddr < 32'(4 * RAM_WORDS));
  assign mmio_hit = (dAddr[31:5] == MMIO_BASE[31:5]);
  assign word_idx = dAddr[AW+1:2];
  assign reg_sel  = dAddr[4:2];
  assign ram_we   = d_wr_en & ram_hit;
  assign mmio_we  = d_wr_en & mmio_hit;
  assign hit      = en_q && (cnt_q == cmp_q);

  always_comb begin
    be       = 4'b0000;
    wdata_al = dWdata;
    case (d_size)
      2'b00: begin
        be[dAddr[1:0]] = 1'b1;
        wdata_al       = {4{dWdata[7:0]}};
      end
      2'b01: begin
        be       = dAddr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{dWdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // RAM is deliberately outside the reset domain; a store on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  always_comb begin
    gpio_d    = gpio_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    autoclr_d = autoclr_q;
    if (mmio_we) begin
      case (reg_sel)
        3'd0: gpio_d = dWdata[GPIO_W-1:0];
        3'd2: cmp_d  = dWdata;
        3'd3: begin
          en_d      = dWdata[0];
          autoclr_d = dWdata[1];
        end
        default: ;
      endcase
    end
    if (mmio_we && reg_sel == 3'd1) cnt_d = dWdata;
    else if (hit && autoclr_q)      cnt_d = 32'd0;
    else if (en_q)                  cnt_d = cnt_q + 32'd1;
    else                            cnt_d = cnt_q;
    // A new match takes precedence over a simultaneous write-1-to-clear.
    match_d = hit | (match_q & ~(mmio_we && reg_sel == 3'd4 && dWdata[0]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= '0;
      cnt_q     <= 32'd0;
      cmp_q     <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      gpio_q    <= gpio_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      autoclr_q <= autoclr_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    rd_word = 32'd0;
    if (ram_hit) begin
      rd_word = mem_q[word_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        3'd0: rd_word[GPIO_W-1:0] = gpio_q;
        3'd1: rd_word = cnt_q;
        3'd2: rd_word = cmp_q;
        3'd3: rd_word = {30'd0, autoclr_q, en_q};
        3'd4: rd_word = {31'd0, match_q};
        default: rd_word = 32'd0;
      endcase
    end
  end

  assign byte_v = rd_word[{dAddr[1:0], 3'b000} +: 8];
  assign half_v = dAddr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (load_type)
      3'b000:  dRdata = {{24{byte_v[7]}}, byte_v};
      3'b001:  dRdata = {{16{half_v[15]}}, half_v};
      3'b100:  dRdata = {24'd0, byte_v};
      3'b101:  dRdata = {16'd0, half_v};
      default: dRdata = rd_word;
    endcase
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = match_q;

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder end of the core's data-memory interface. Decodes `dAddr`, performs byte, half and word stores into a local RAM, and returns `load_type`-extended read data on `dRdata`.
- Also hosts a memory-mapped GPIO output register and a compare timer with an interrupt flag.
- Sits beside the RV32I core. Reads are combinational, to suit the single-cycle datapath. Writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; RAM occupies 0x0000_0000 to 4*RAM_WORDS-1.
- MMIO_BASE, 32'h1000_0000, base address of the peripheral register block.
- GPIO_W, 16, width of the GPIO output register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all registers immediately.
- d_wr_en  in  1  store strobe, sampled at the clk edge.
- dAddr  in  32  byte address.
- dWdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- d_size  in  2  store size: 00 byte, 01 half, 10 word, 11 treated as word.
- load_type  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others behave as LW.
- dRdata  out  32  combinational, extended load data.
- gpio_out  out  GPIO_W  GPIO register contents.
- timer_irq  out  1  level interrupt, equals the timer match flag.

Behaviour:
- Decode
  - RAM hit: dAddr < 4*RAM_WORDS; word index is dAddr[log2(RAM_WORDS)+1:2].
  - MMIO hit: dAddr[31:5] == MMIO_BASE[31:5]; register select is dAddr[4:2].
  - Anything else is unmapped: reads return 0, writes are ignored.
- MMIO register map (offsets from MMIO_BASE)
  - 0x00 GPIO_OUT, R/W, low GPIO_W bits; upper bits read as 0.
  - 0x04 TIMER_CNT, R/W.
  - 0x08 TIMER_CMP, R/W.
  - 0x0C TIMER_CTRL: bit0 EN, bit1 AUTOCLR; other bits read as 0.
  - 0x10 TIMER_STAT: bit0 MATCH; writing 1 clears it.
  - 0x14 to 0x1C: read 0, writes ignored.
- Stores to RAM
  - Byte: lane dAddr[1:0] receives dWdata[7:0]; other lanes unchanged.
  - Half: lanes {dAddr[1],0} and {dAddr[1],1} receive dWdata[15:0]; dAddr[0] is ignored.
  - Word: full word is written; dAddr[1:0] is ignored.
- Stores to MMIO
  - Always full-word, whatever d_size is; dAddr[1:0] is ignored.
- Loads, for RAM and MMIO alike
  - The selected word is shifted by the lane, then extended per load_type.
  - LB/LBU sign/zero-extend lane dAddr[1:0].
  - LH/LHU sign/zero-extend the half at dAddr[1].
  - LW returns the whole word.
  - dRdata is valid in the same cycle as dAddr; it has no side effects and does not depend on d_wr_en.
  - A read in the same cycle as a write to the same location returns the old value; the new value is visible in the next cycle.
- Timer, per clk edge, in priority order
  - (1) A CPU write to TIMER_CNT loads dWdata.
  - (2) Else, if EN and CNT==CMP and AUTOCLR, CNT becomes 0.
  - (3) Else, if EN, CNT becomes CNT+1, wrapping 0xFFFF_FFFF to 0.
- Match flag
  - MATCH sets on any edge where EN=1 and CNT==CMP, using pre-edge values.
  - If set and a write-1-to-clear occur on the same edge, set wins.
  - Writing 0 to TIMER_STAT has no effect.
- Reset (reset=0)
  - gpio_out=0, CNT=0, CMP=0xFFFF_FFFF, CTRL=0, MATCH=0, timer_irq=0.
  - RAM contents are not reset; they are preserved across reset.
  - Reset asserted mid-count clears the timer immediately and asynchronously.
  - A store coinciding with reset assertion is dropped.

Test Plan:
- SW 0x1122_3344 to 0x10, then SB 0xAA to 0x12, then LW 0x10 -> 0x11AA_3344; LB 0x12 -> 0xFFFF_FFAA; LBU 0x12 -> 0x0000_00AA.
- SH 0x8001 to 0x22, then LH 0x22 -> 0xFFFF_8001; LHU 0x22 -> 0x0000_8001; LW 0x20 -> 0x8001_xxxx with the low half unchanged.
- Write CMP=5 and CTRL=3 -> CNT counts 0..5; MATCH/timer_irq rise on the edge after CNT==5; CNT returns to 0 on that edge and then counts again.
- With MATCH=1, write TIMER_STAT=1 on the same edge as a new match -> MATCH stays 1; the same write with no match -> MATCH=0 on the next cycle.
- Write GPIO_OUT=0xDEAD_BEEF -> gpio_out=0xBEEF, readback 0x0000_BEEF; LW from 0x2000_0000 -> 0; a write there changes no state.
- Run the timer with CNT=100, then pulse reset low between edges -> CNT=0, CTRL=0 and timer_irq=0 immediately; RAM word 0x10 still reads 0x11AA_3344.
